spi_master: RTL and testbench

SPI master controller. It is the initiating end of the link that our SPI slave block serves.
- Pops words from a first-word-fall-through TX FIFO.
- Drives SCLK, CSn and MOSI, and samples MISO.
- Pushes each received word into an RX FIFO.
- Supports all four CPOL/CPHA modes, frame length 1–16 bits (MSB first) and a programmable SCLK divider. Sits on the SoC peripheral bus behind the control unit registers.

---
 rtl/spi_pkg.sv | 10 +
 rtl/spi_clkgen.sv | 72 +++++++
 rtl/spi_master.sv | 141 ++++++++++++++
 tb/tb_spi_master.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master and its clock generator.
package spi_pkg;
  localparam int DW_DEF   = 16;
  localparam int DIVW_DEF = 8;
  localparam int ECW      = 5;  // counts up to 2*16 SCLK toggles
  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_e;
endpackage

// File: rtl/spi_clkgen.sv
// Half-period divider and SCLK toggle generator; flags leading/trailing edges on the tick
// that launches them, so the master acts in the same cycle the pin changes.
module spi_clkgen
  import spi_pkg::*;
#(
  parameter int DIVW = DIVW_DEF
) (
  input  logic            sclk_sample,
  input  logic            rst,
  input  logic            load,
  input  logic            run,
  input  logic            xfer,
  input  logic [DIVW-1:0] div_in,
  input  logic            cpol_in,
  output logic            tick,
  output logic            lead_edge,
  output logic            trail_edge,
  output logic [ECW-1:0]  edge_cnt,
  output logic            sclk
);
  logic [DIVW-1:0] div_q, div_d;
  logic [DIVW-1:0] cnt_q, cnt_d;
  logic [ECW-1:0]  edge_q, edge_d;
  logic            cpol_q, cpol_d;
  logic            sclk_q, sclk_d;

  assign tick       = run && (cnt_q == '0);
  assign lead_edge  = tick && xfer && !edge_q[0];
  assign trail_edge = tick && xfer && edge_q[0];
  assign edge_cnt   = edge_q;
  assign sclk       = sclk_q;

  always_comb begin
    div_d  = div_q;
    cpol_d = cpol_q;
    cnt_d  = cnt_q;
    edge_d = edge_q;
    sclk_d = sclk_q;
    if (load) begin
      div_d  = div_in;
      cpol_d = cpol_in;
      cnt_d  = div_in;
      edge_d = '0;
      sclk_d = cpol_in;
    end else if (run) begin
      cnt_d = (cnt_q == '0) ? div_q : cnt_q - DIVW'(1);
      if (tick && xfer) begin
        edge_d = edge_q + ECW'(1);
        sclk_d = !sclk_q;
      end
    end else begin
      // Idle clock level tracks the live CPOL setting.
      sclk_d = cpol_in;
    end
  end

  always_ff @(posedge sclk_sample or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      cpol_q <= 1'b0;
      cnt_q  <= '0;
      edge_q <= '0;
      sclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      cpol_q <= cpol_d;
      cnt_q  <= cnt_d;
      edge_q <= edge_d;
      sclk_q <= sclk_d;
    end
  end
endmodule

// File: rtl/spi_master.sv
// SPI master: pops a TX word, runs one CPOL/CPHA frame of LEN+1 bits MSB first,
// pushes the right-aligned received word. Config is captured at frame start.
module spi_master
  import spi_pkg::*;
#(
  parameter int DIVW = DIVW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic            sclk_sample,
  input  logic            rst,
  input  logic            i_tx_empty,
  output logic            o_rd_TX,
  input  logic [DW-1:0]   i_dataTX,
  input  logic            i_rx_full,
  output logic            o_wr_RX,
  output logic [DW-1:0]   o_dataRX,
  input  logic [1:0]      CPolPha,
  input  logic [3:0]      LEN,
  input  logic [DIVW-1:0] DIV,
  input  logic            i_en,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_SCLK,
  output logic            o_MOSI,
  input  logic            i_MISO,
  output logic            o_CSn
);
  state_e          state_q, state_d;
  logic [DW-1:0]   tx_q, tx_d;
  logic [DW-1:0]   rx_q, rx_d;
  logic [DW-1:0]   data_rx_q, data_rx_d;
  logic [3:0]      len_q, len_d;
  logic            cpha_q, cpha_d;
  logic            mosi_q, mosi_d;
  logic            cs_n_q, cs_n_d;
  logic            wr_rx_q, wr_rx_d;
  logic            done_q, done_d;

  logic            start, tick, lead_edge, trail_edge, last_edge;
  logic            sample_edge, drive_edge;
  logic [ECW-1:0]  edge_cnt;
  logic [DW-1:0]   tx_al;

  assign start       = (state_q == IDLE) && i_en && !i_tx_empty && !i_rx_full && !rst;
  // Left-align the frame so the first bit out is always the register MSB.
  assign tx_al       = i_dataTX << (4'(DW - 1) - LEN);
  assign last_edge   = (edge_cnt == {len_q, 1'b1});
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign drive_edge  = cpha_q ? lead_edge : trail_edge;

  spi_clkgen #(.DIVW(DIVW)) u_clkgen (
    .sclk_sample (sclk_sample),
    .rst         (rst),
    .load        (start),
    .run         (state_q != IDLE),
    .xfer        (state_q == XFER),
    .div_in      (DIV),
    .cpol_in     (CPolPha[CPOL_BIT]),
    .tick        (tick),
    .lead_edge   (lead_edge),
    .trail_edge  (trail_edge),
    .edge_cnt    (edge_cnt),
    .sclk        (o_SCLK)
  );

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    data_rx_d = data_rx_q;
    len_d     = len_q;
    cpha_d    = cpha_q;
    mosi_d    = mosi_q;
    wr_rx_d   = 1'b0;
    done_d    = 1'b0;
    o_rd_TX   = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        o_rd_TX = 1'b1;
        tx_d    = tx_al;
        rx_d    = '0;
        len_d   = LEN;
        cpha_d  = CPolPha[CPHA_BIT];
        if (!CPolPha[CPHA_BIT]) mosi_d = tx_al[DW-1];
        state_d = SETUP;
      end
      SETUP: if (tick) state_d = XFER;
      XFER: begin
        if (sample_edge) rx_d = {rx_q[DW-2:0], i_MISO};
        // CPHA=0 already presented bit LEN in SETUP, so it drives one bit ahead.
        if (drive_edge && !(!cpha_q && last_edge)) begin
          mosi_d = cpha_q ? tx_q[DW-1] : tx_q[DW-2];
          tx_d   = tx_q << 1;
        end
        if (trail_edge && last_edge) state_d = HOLD;
      end
      HOLD: if (tick) begin
        wr_rx_d   = 1'b1;
        done_d    = 1'b1;
        data_rx_d = rx_q;
        state_d   = GAP;
      end
      GAP: if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cs_n_d = !((state_d == SETUP) || (state_d == XFER) || (state_d == HOLD));
  end

  always_ff @(posedge sclk_sample or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tx_q      <= '0;
      rx_q      <= '0;
      data_rx_q <= '0;
      len_q     <= '0;
      cpha_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      wr_rx_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      data_rx_q <= data_rx_d;
      len_q     <= len_d;
      cpha_q    <= cpha_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      wr_rx_q   <= wr_rx_d;
      done_q    <= done_d;
    end
  end

  assign o_CSn    = cs_n_q;
  assign o_MOSI   = mosi_q;
  assign o_wr_RX  = wr_rx_q;
  assign o_done   = done_q;
  assign o_dataRX = data_rx_q;
  assign o_busy   = (state_q != IDLE);
endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: FWFT TX FIFO model, RX capture, edge monitor, mode-3 slave model.
module tb_spi_master;
  logic        sclk_sample = 1'b0;
  logic        rst = 1'b0;
  logic        i_tx_empty, o_rd_TX, i_rx_full, o_wr_RX;
  logic [15:0] i_dataTX, o_dataRX;
  logic [1:0]  CPolPha;
  logic [3:0]  LEN;
  logic [7:0]  DIV;
  logic        i_en, o_busy, o_done, o_SCLK, o_MOSI, i_MISO, o_CSn;

  int n_vec = 0, n_err = 0;

  logic [15:0] txq[$];
  logic [15:0] rxq[$];
  logic        pop_req = 1'b0;
  logic        loop = 1'b1, miso_s = 1'b0;
  logic [15:0] slave_word = 16'h0, sl_sh = 16'h0, mosi_cap = 16'h0;

  int   rd_cnt = 0, wr_cnt = 0, done_cnt = 0, done_wr_mis = 0, busy_falls = 0;
  int   toggles = 0, cs_low = 0, cs_high_run = 0, gap_len = 0;
  int   mosi_chg = 0, mosi_bad = 0;
  logic sclk_at_cs = 1'b0, first_lvl = 1'b0, mosi_edge_lvl = 1'b1;
  logic prev_cs_n = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0, prev_busy = 1'b0;

  assign i_MISO = loop ? o_MOSI : miso_s;

  spi_master dut (
    .sclk_sample (sclk_sample), .rst (rst),
    .i_tx_empty (i_tx_empty), .o_rd_TX (o_rd_TX), .i_dataTX (i_dataTX),
    .i_rx_full (i_rx_full), .o_wr_RX (o_wr_RX), .o_dataRX (o_dataRX),
    .CPolPha (CPolPha), .LEN (LEN), .DIV (DIV), .i_en (i_en),
    .o_busy (o_busy), .o_done (o_done), .o_SCLK (o_SCLK), .o_MOSI (o_MOSI),
    .i_MISO (i_MISO), .o_CSn (o_CSn)
  );

  always #5 sclk_sample = ~sclk_sample;

  // Monitor: samples everything on the falling clock edge.
  always @(negedge sclk_sample) begin
    if (!o_CSn) begin
      if (prev_cs_n) begin
        toggles = 0; cs_low = 0; sclk_at_cs = o_SCLK; gap_len = cs_high_run;
      end else if (o_SCLK !== prev_sclk) begin
        toggles++;
        if (toggles == 1) first_lvl = o_SCLK;
      end
      if (!prev_cs_n && (o_MOSI !== prev_mosi)) begin
        mosi_chg++;
        if ((o_SCLK === prev_sclk) || (o_SCLK !== mosi_edge_lvl)) mosi_bad++;
      end
      cs_low++;
      cs_high_run = 0;
    end else begin
      cs_high_run++;
    end
    if (o_rd_TX) begin rd_cnt++; pop_req = 1'b1; end
    if (o_wr_RX) begin wr_cnt++; rxq.push_back(o_dataRX); end
    if (o_done) done_cnt++;
    if (o_done !== o_wr_RX) done_wr_mis++;
    if (prev_busy && !o_busy) busy_falls++;
    prev_cs_n = o_CSn; prev_sclk = o_SCLK; prev_mosi = o_MOSI; prev_busy = o_busy;
  end

  // FWFT FIFO pop lands just after the clock edge that consumed the head.
  always @(posedge sclk_sample) begin
    #1;
    if (pop_req) begin
      if (txq.size() != 0) txq.delete(0);
      pop_req    = 1'b0;
      i_tx_empty = (txq.size() == 0);
      i_dataTX   = i_tx_empty ? 16'h0 : txq[0];
    end
  end

  // Mode-3 slave: loads its word at CSn fall, shifts out on each falling (leading) SCLK edge.
  always @(negedge o_CSn) sl_sh = slave_word;
  always @(negedge o_SCLK) begin
    if (o_CSn === 1'b0) begin
      #1;
      miso_s = sl_sh[15];
      sl_sh  = sl_sh << 1;
    end
  end
  always @(posedge o_SCLK) if (o_CSn === 1'b0) mosi_cap = {mosi_cap[14:0], o_MOSI};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sclk_sample);
    #2;
  endtask

  task automatic push(input logic [15:0] w);
    txq.push_back(w);
    i_tx_empty = 1'b0;
    i_dataTX   = txq[0];
  endtask

  task automatic chk_rx(input string tag, input logic [15:0] exp);
    logic [31:0] got;
    got = 32'hFFFF_FFFF;
    if (rxq.size() != 0) begin
      got = {16'h0, rxq[0]};
      rxq.delete(0);
    end
    chk(tag, got, {16'h0, exp});
  endtask

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (done_cnt < target && k < budget) begin step(); k++; end
    chk("done_timeout", 32'(done_cnt >= target), 1);
    repeat (12) step();
  endtask

  initial begin
    int rd0, wr0, dn0, bf0, k;
    i_en = 1'b0; i_rx_full = 1'b0; i_tx_empty = 1'b1; i_dataTX = 16'h0;
    CPolPha = 2'b00; LEN = 4'd7; DIV = 8'd1;
    #1 rst = 1'b1;
    repeat (3) step();
    chk("rst_csn",    32'(o_CSn),    1);
    chk("rst_sclk",   32'(o_SCLK),   0);
    chk("rst_mosi",   32'(o_MOSI),   0);
    chk("rst_rd",     32'(o_rd_TX),  0);
    chk("rst_wr",     32'(o_wr_RX),  0);
    chk("rst_data",   32'(o_dataRX), 0);
    chk("rst_busy",   32'(o_busy),   0);
    chk("rst_done",   32'(o_done),   0);
    rst = 1'b0;
    step();
    i_en = 1'b1;

    // Mode 0, 8 bits, DIV=1, loopback
    rd0 = rd_cnt; wr0 = wr_cnt;
    push(16'h00A5);
    wait_done(1, 300);
    chk("m0_rd_pulses", 32'(rd_cnt - rd0), 1);
    chk("m0_wr_pulses", 32'(wr_cnt - wr0), 1);
    chk("m0_toggles",   32'(toggles), 16);
    chk("m0_sclk_at_cs", 32'(sclk_at_cs), 0);
    chk("m0_first_edge", 32'(first_lvl), 1);
    chk("m0_cs_low",    32'(cs_low), 36);
    chk("m0_done_wr",   32'(done_wr_mis), 0);
    chk_rx("m0_rx", 16'h00A5);

    // Mode 3, 16 bits, DIV=0, slave returns BEEF
    CPolPha = 2'b11; LEN = 4'd15; DIV = 8'd0; loop = 1'b0; slave_word = 16'hBEEF;
    step(); step();
    chk("m3_sclk_idle", 32'(o_SCLK), 1);
    mosi_cap = 16'h0;
    push(16'h1234);
    wait_done(2, 300);
    chk("m3_mosi_stream", 32'(mosi_cap), 32'h1234);
    chk("m3_toggles", 32'(toggles), 32);
    chk("m3_cs_low",  32'(cs_low), 34);
    chk_rx("m3_rx", 16'hBEEF);

    // Mode 1, 4 bits: MOSI moves only on leading (rising) edges
    CPolPha = 2'b01; LEN = 4'd3; DIV = 8'd1; loop = 1'b1; mosi_edge_lvl = 1'b1;
    step(); step();
    mosi_chg = 0; mosi_bad = 0;
    push(16'h000C);
    wait_done(3, 300);
    chk("m1_mosi_bad", 32'(mosi_bad), 0);
    chk("m1_mosi_chg", 32'(mosi_chg), 2);
    chk_rx("m1_rx", 16'h000C);

    // Mode 2, 4 bits: MOSI moves only on trailing (rising back to CPOL) edges
    CPolPha = 2'b10; LEN = 4'd3; DIV = 8'd3; mosi_edge_lvl = 1'b1;
    step(); step();
    mosi_chg = 0; mosi_bad = 0;
    push(16'h000C);
    wait_done(4, 300);
    chk("m2_mosi_bad", 32'(mosi_bad), 0);
    chk("m2_mosi_chg", 32'(mosi_chg), 1);
    chk("m2_toggles",  32'(toggles), 8);
    chk_rx("m2_rx", 16'h000C);

    // Back-to-back frames, DIV=2
    CPolPha = 2'b00; LEN = 4'd7; DIV = 8'd2;
    step(); step();
    bf0 = busy_falls;
    push(16'h0011);
    push(16'h0022);
    wait_done(6, 600);
    chk("b2b_gap",        32'(gap_len), 4);
    chk("b2b_busy_falls", 32'(busy_falls - bf0), 2);
    chk_rx("b2b_rx0", 16'h0011);
    chk_rx("b2b_rx1", 16'h0022);

    // RX full blocks the start
    i_rx_full = 1'b1;
    rd0 = rd_cnt;
    push(16'h0077);
    repeat (8) step();
    chk("rxfull_no_rd", 32'(rd_cnt - rd0), 0);
    chk("rxfull_csn",   32'(o_CSn), 1);
    i_rx_full = 1'b0;
    #1 chk("rxfull_rel_rd", 32'(o_rd_TX), 1);
    step();
    chk("rxfull_rel_cs", 32'(o_CSn), 0);
    wait_done(7, 600);
    chk_rx("rxfull_rx", 16'h0077);

    // Reset mid-frame at toggle 5
    CPolPha = 2'b00; LEN = 4'd7; DIV = 8'd1;
    step();
    wr0 = wr_cnt; dn0 = done_cnt;
    push(16'h005A);
    k = 0;
    while (!(o_CSn === 1'b0 && toggles == 5) && k < 200) begin step(); k++; end
    chk("rst_reach_tog5", 32'(k < 200), 1);
    chk("rst_busy_pre",   32'(o_busy), 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_csn",  32'(o_CSn), 1);
    chk("rst_mid_sclk", 32'(o_SCLK), 0);
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_no_wr",   32'(wr_cnt - wr0), 0);
    chk("rst_no_done", 32'(done_cnt - dn0), 0);
    push(16'h003C);
    wait_done(dn0 + 1, 300);
    chk_rx("rst_next_rx", 16'h003C);
    chk("rx_no_stray", 32'(rxq.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
